// File: rtl/ras.sv
// ras: return address stack with a speculative front-end copy repaired from a committed copy on flush
module ras #(
    parameter int DEPTH = 8,
    parameter int AW    = 30
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          f_push_i,
    input  logic          f_pop_i,
    input  logic [AW-1:0] f_pc_i,
    output logic [AW-1:0] top_o,
    output logic          top_valid_o,
    input  logic          stall_i,
    input  logic          upd_valid_i,
    input  logic          upd_flush_i,
    input  logic [1:0]    upd_br_type_i,
    input  logic [AW-1:0] upd_pc_i,
    input  logic          csr_flush_i
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
    localparam logic [1:0] BR_CALL = 2'd2;
    localparam logic [1:0] BR_RETURN = 2'd3;

    logic [AW-1:0] spec_stk [DEPTH];
    logic [AW-1:0] com_stk [DEPTH];
    logic [AW-1:0] spec_n [DEPTH];
    logic [AW-1:0] com_n [DEPTH];
    logic [PW-1:0] sp, cp, sp_n, cp_n;
    logic [PW:0]   sc, cc, sc_n, cc_n;
    logic          commit, rflush;

    assign commit = upd_valid_i & ~stall_i;
    assign rflush = (upd_flush_i & ~stall_i) | csr_flush_i;
    assign top_valid_o = sc != '0;
    assign top_o = top_valid_o ? spec_stk[sp] : '0;

    always_comb begin
        com_n = com_stk;
        cp_n = cp;
        cc_n = cc;
        if (commit && upd_br_type_i == BR_CALL) begin
            cp_n = cp + 1'b1;
            com_n[cp_n] = upd_pc_i + 1'b1;
            cc_n = (cc == FULL) ? cc : cc + 1'b1;
        end else if (commit && upd_br_type_i == BR_RETURN && cc != '0) begin
            cp_n = cp - 1'b1;
            cc_n = cc - 1'b1;
        end
    end

    // flush takes the committed stack including this cycle's commit op
    always_comb begin
        spec_n = spec_stk;
        sp_n = sp;
        sc_n = sc;
        if (rflush) begin
            spec_n = com_n;
            sp_n = cp_n;
            sc_n = cc_n;
        end else if (f_push_i && f_pop_i && sc != '0) begin
            spec_n[sp] = f_pc_i + 1'b1;
        end else if (f_push_i) begin
            sp_n = sp + 1'b1;
            spec_n[sp_n] = f_pc_i + 1'b1;
            sc_n = (sc == FULL) ? sc : sc + 1'b1;
        end else if (f_pop_i && sc != '0) begin
            sp_n = sp - 1'b1;
            sc_n = sc - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spec_stk <= '{default: '0};
            com_stk <= '{default: '0};
            sp <= '0;
            cp <= '0;
            sc <= '0;
            cc <= '0;
        end else begin
            spec_stk <= spec_n;
            com_stk <= com_n;
            sp <= sp_n;
            cp <= cp_n;
            sc <= sc_n;
            cc <= cc_n;
        end
    end

    a_spec_cnt: assert property (@(posedge clk) disable iff (!rst_n) sc <= FULL);
    a_com_cnt: assert property (@(posedge clk) disable iff (!rst_n) cc <= FULL);
    a_valid: assert property (@(posedge clk) disable iff (!rst_n) top_valid_o == (sc != '0));
endmodule

// File: tb/tb_ras.sv
// tb_ras: directed and random checks of ras against a queue-based return-stack model
module tb_ras;
    localparam int DEPTH = 8;
    localparam int AW = 30;
    localparam logic [1:0] BR_REL = 2'd0;
    localparam logic [1:0] BR_ABS = 2'd1;
    localparam logic [1:0] BR_CALL = 2'd2;
    localparam logic [1:0] BR_RET = 2'd3;

    logic          clk = 0;
    logic          rst_n = 0;
    logic          f_push_i = 0, f_pop_i = 0;
    logic [AW-1:0] f_pc_i = '0;
    logic [AW-1:0] top_o;
    logic          top_valid_o;
    logic          stall_i = 0, upd_valid_i = 0, upd_flush_i = 0, csr_flush_i = 0;
    logic [1:0]    upd_br_type_i = BR_REL;
    logic [AW-1:0] upd_pc_i = '0;

    int compared = 0;
    int mismatched = 0;
    logic [AW-1:0] ms[$];
    logic [AW-1:0] mc[$];

    ras #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .f_push_i(f_push_i), .f_pop_i(f_pop_i), .f_pc_i(f_pc_i),
        .top_o(top_o), .top_valid_o(top_valid_o),
        .stall_i(stall_i), .upd_valid_i(upd_valid_i), .upd_flush_i(upd_flush_i),
        .upd_br_type_i(upd_br_type_i), .upd_pc_i(upd_pc_i), .csr_flush_i(csr_flush_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag);
        logic [AW-1:0] et;
        logic ev;
        ev = ms.size() != 0;
        et = ev ? ms[ms.size()-1] : '0;
        compared++;
        assert (top_valid_o === ev) else begin
            mismatched++;
            $error("FAIL %s top_valid_o got=%0b exp=%0b", tag, top_valid_o, ev);
        end
        compared++;
        assert (top_o === et) else begin
            mismatched++;
            $error("FAIL %s top_o got=%h exp=%h", tag, top_o, et);
        end
    endtask

    task automatic step(input string tag, input bit fp, input bit fo, input logic [AW-1:0] fpc,
                        input bit uv, input bit uf, input logic [1:0] bt, input logic [AW-1:0] upc,
                        input bit st, input bit cs);
        logic [AW-1:0] v;
        f_push_i = fp; f_pop_i = fo; f_pc_i = fpc;
        upd_valid_i = uv; upd_flush_i = uf; upd_br_type_i = bt; upd_pc_i = upc;
        stall_i = st; csr_flush_i = cs;
        if (uv && !st) begin
            if (bt == BR_CALL) begin
                v = upc + 1;
                mc.push_back(v);
                if (mc.size() > DEPTH) void'(mc.pop_front());
            end else if (bt == BR_RET && mc.size() != 0) void'(mc.pop_back());
        end
        if ((uf && !st) || cs) ms = mc;
        else if (fp && fo && ms.size() != 0) ms[ms.size()-1] = fpc + 1;
        else if (fp) begin
            v = fpc + 1;
            ms.push_back(v);
            if (ms.size() > DEPTH) void'(ms.pop_front());
        end else if (fo && ms.size() != 0) void'(ms.pop_back());
        @(posedge clk);
        #1;
        f_push_i = 0; f_pop_i = 0; upd_valid_i = 0; upd_flush_i = 0; stall_i = 0; csr_flush_i = 0;
        chk(tag);
    endtask

    task automatic fpush(input string tag, input logic [AW-1:0] pc);
        step(tag, 1, 0, pc, 0, 0, BR_REL, '0, 0, 0);
    endtask

    task automatic fpop(input string tag);
        step(tag, 0, 1, '0, 0, 0, BR_REL, '0, 0, 0);
    endtask

    initial begin
        #1;
        chk("reset");
        @(negedge clk) rst_n = 1;
        @(posedge clk) #1;
        fpush("push0", 30'h0FF);
        fpush("push1", 30'h1FF);
        fpop("pop0");
        fpop("pop1");
        fpop("pop_empty");
        for (int i = 0; i < 9; i++) fpush("ovf_push", AW'(i));
        for (int i = 0; i < 8; i++) fpop("ovf_pop");
        fpop("ovf_empty");
        fpush("pp_setup", 30'h40);
        step("push_pop", 1, 1, 30'h7F, 0, 0, BR_REL, '0, 0, 0);
        fpop("pp_depth");
        step("pp_empty", 1, 1, 30'h13, 0, 0, BR_REL, '0, 0, 0);
        fpop("pp_empty_pop");
        step("com_call0", 1, 0, 30'h40, 1, 0, BR_CALL, 30'h40, 0, 0);
        step("com_call1", 1, 0, 30'h80, 1, 0, BR_CALL, 30'h80, 0, 0);
        fpush("spec_extra", 30'h5FF);
        step("repair", 1, 0, 30'h777, 1, 1, BR_RET, 30'hC0, 0, 0);
        fpush("stall_setup", 30'h100);
        step("stall", 0, 0, '0, 1, 1, BR_CALL, 30'h300, 1, 0);
        step("csr", 0, 0, '0, 0, 0, BR_REL, '0, 0, 1);
        fpop("csr_depth");
        fpop("csr_empty");
        step("wrap", 1, 0, 30'h3FFFFFFF, 1, 0, BR_CALL, 30'h3FFFFFFF, 0, 0);
        for (int i = 0; i < 3; i++) fpush("rst_setup", AW'(i + 16));
        rst_n = 0;
        ms.delete();
        mc.delete();
        #1;
        chk("rst_mid");
        @(negedge clk) rst_n = 1;
        fpop("rst_pop");
        step("rst_csr", 0, 0, '0, 0, 0, BR_REL, '0, 0, 1);
        for (int i = 0; i < 800; i++) begin
            logic [AW-1:0] p, q;
            int r;
            r = $urandom_range(0, 99);
            p = (r < 5) ? {AW{1'b1}} : AW'($urandom);
            q = AW'($urandom);
            step("rand", $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 40, p,
                 $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 8, 2'($urandom_range(0, 3)), q,
                 $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 4);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/ras.md
Name: ras

Overview:
- Return address stack for the branch prediction unit.
- Speculative half: push/pop each cycle from front-end predictions (predicted CALL / RETURN); top of stack supplies the predicted return target.
- Committed half: updated from the branch-feedback stage's update bundle (br_type, pc, flush) once the branch resolves.
- On a misprediction flush, the speculative stack is repaired from the committed stack.

Parameters:
- DEPTH, 8, number of entries (power of two, >=2).
- AW, 30, address width in words (PC[31:2]).

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- f_push_i  input  1  front-end predicts CALL this cycle
- f_pop_i  input  1  front-end predicts RETURN this cycle
- f_pc_i  input  AW  word PC of the predicted CALL; value pushed is f_pc_i+1
- top_o  output  AW  predicted return target (speculative top)
- top_valid_o  output  1  speculative stack non-empty
- stall_i  input  1  feedback stage stalled; commit-side inputs ignored
- upd_valid_i  input  1  resolved branch present (update bht_update)
- upd_flush_i  input  1  resolved branch mispredicted (update flush)
- upd_br_type_i  input  2  resolved type: `_CALL / `_RETURN / `_ABSOLUTE / `_PC_RELATIVE (bpu.svh)
- upd_pc_i  input  AW  word PC of resolved branch
- csr_flush_i  input  1  exception/ertn flush, no branch correction

Behaviour:
- Reset (async, rst_n=0):
  - All entries of both stacks = 0; pointers = 0; counts = 0.
  - top_o=0, top_valid_o=0.
  - Reset mid-operation discards everything immediately.
- Storage and outputs:
  - Each stack: DEPTH x AW register array, circular top pointer (log2 DEPTH bits, wraps), count 0..DEPTH.
  - top_o / top_valid_o: combinational from registered speculative state; zero latency.
  - top_o = spec[sp] when count>0, else 0.
- Push: pointer+1 (wrap), write value at new pointer, count = min(count+1, DEPTH). When full, the oldest entry is silently overwritten.
- Pop: count>0: pointer-1 (wrap), count-1. count==0: no-op, no pointer change.
- Front-end side (speculative), when no flush this cycle:
  - push only: push f_pc_i+1.
  - pop only: pop.
  - push and pop together: overwrite top entry with f_pc_i+1, pointer unchanged. If count==0, this behaves as a push.
- Commit side, qualified by commit = upd_valid_i & ~stall_i:
  - `_CALL: push upd_pc_i+1.
  - `_RETURN: pop.
  - Other types: no change.
- Repair, qualified by rflush = (upd_flush_i & ~stall_i) | csr_flush_i:
  - Speculative array, pointer and count are loaded from the committed state's NEXT value, i.e. including this cycle's commit-side op.
  - Front-end push/pop in the same cycle is ignored (flush wins).
  - csr_flush_i: restore only. Its commit op is applied only if upd_valid_i & ~stall_i. csr_flush_i is not gated by stall_i.
- Visibility: repaired top is visible on top_o the cycle after rflush.
- Arithmetic: f_pc_i+1 and upd_pc_i+1 are AW-bit, wrap modulo 2^AW.
- No other state; no FSM beyond the two stacks; single-cycle ops, no backpressure.
- Assertions:
  - count <= DEPTH always.
  - top_valid_o == (spec count != 0).

Test Plan:
- Reset: rst_n=0 mid-stream with 3 entries pushed -> immediately top_valid_o=0, top_o=0; after release, pop is a no-op.
- Push/pop:
  - Stimulus: f_push f_pc=0x0FF, then f_push f_pc=0x1FF.
  - Expect top_o=0x200. Pop -> 0x100. Pop -> top_valid_o=0, top_o=0. Third pop -> still empty, no wrap.
- Overflow (DEPTH=8): 9 pushes with f_pc=0..8 -> count=8; 8 pops return 9,8,...,2; then top_valid_o=0.
- Simultaneous push+pop with top=0x41: f_pc=0x7F, push and pop both asserted -> top_o=0x80, depth unchanged.
- Misprediction repair:
  - Setup: commit `_CALL pc 0x40 and 0x80 (committed 0x41, 0x81); speculative additionally pushed 0x600.
  - Stimulus: upd_valid=1, upd_flush=1, br_type=`_RETURN, pc 0xC0, with f_push asserted the same cycle.
  - Expect: next cycle top_o=0x41, depth 1; f_push ignored.
- Stall / CSR:
  - stall_i=1 with upd_valid=1, upd_flush=1, `_CALL -> neither stack changes.
  - Then csr_flush_i=1 alone -> speculative equals committed next cycle, no correction push.
